// File: rtl/thermo_spi_pkg.sv
// Shared definitions for the thermocouple SPI responder: frame layout,
// FSM state encoding and a frame-building helper.
package thermo_spi_pkg;

  localparam int FRAME_W  = 16;
  localparam int TEMP_W   = 12;
  localparam int TEMP_MSB = 14;
  localparam int TEMP_LSB = 3;
  localparam int OPEN_BIT = 2;
  localparam int ID_BIT   = 1;
  localparam int BITCNT_W = 5;

  typedef enum logic [1:0] {
    CONVERT = 2'd0,
    READY   = 2'd1,
    SHIFT   = 2'd2
  } state_t;

  // Assemble the 16-bit read frame: {0, temp[11:0], open_tc, id=0, 0}.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [TEMP_W-1:0] temp,
                                                     input logic              open_bit);
    logic [FRAME_W-1:0] f;
    f                    = {FRAME_W{1'b0}};
    f[TEMP_MSB:TEMP_LSB] = temp;
    f[OPEN_BIT]          = open_bit;
    f[ID_BIT]            = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/thermo_spi_responder_if.sv
// SPI read link between the temperature reader (master) and the responder.
interface thermo_spi_if;
  logic cs;
  logic sck;
  logic so;

  modport master (output cs, output sck, input so);
  modport slave  (input cs, input sck, output so);
endinterface

// File: rtl/spi_sync_edge.sv
// Synchronizes an asynchronous pin into the clk domain and produces
// single-cycle rise/fall pulses from the synchronized level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchronizer chain plus one edge-history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/thermo_spi_responder.sv
// MAX6675-style thermocouple converter emulation on the slave side of a
// 16-bit SPI read link. Optional feature macro: THERMO_OPEN_TC_EN (when
// defined, open_tc is captured into frame bit 2; otherwise bit 2 reads 0).
module thermo_spi_responder
  import thermo_spi_pkg::*;
#(
  parameter int CONV_CYCLES = 11_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  thermo_spi_if.slave       spi,
  input  logic [TEMP_W-1:0] temp_in,
  input  logic              open_tc,
  output logic              conv_ready,
  output logic              frame_done
);

  localparam int                CONV_W    = $clog2(CONV_CYCLES);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);

  state_t               r_state;
  state_t               w_next;
  logic [CONV_W-1:0]    r_conv_cnt;
  logic [TEMP_W-1:0]    r_hold_temp;
  logic                 r_hold_open;
  logic [FRAME_W-1:0]   r_shreg;
  logic [BITCNT_W-1:0]  r_bit_cnt;
  logic                 r_so;
  logic                 r_conv_ready;
  logic                 r_frame_done;

  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_open_eff;
  logic w_enter_shift, w_leave_shift, w_conv_done, w_shift_bit;

`ifdef THERMO_OPEN_TC_EN
  assign w_open_eff = open_tc;
`else
  assign w_open_eff = 1'b0;
`endif

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     (spi.cs),
    .o_level (w_cs_level),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     (spi.sck),
    .o_level (w_sck_level),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CONVERT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and transition strobes; a cs fall takes priority over conversion end.
  always_comb begin
    w_next        = r_state;
    w_enter_shift = 1'b0;
    w_leave_shift = 1'b0;
    w_conv_done   = 1'b0;
    case (r_state)
      CONVERT: begin
        if (w_cs_fall) begin
          w_next        = SHIFT;
          w_enter_shift = 1'b1;
        end else if (r_conv_cnt == CONV_LAST) begin
          w_next      = READY;
          w_conv_done = 1'b1;
        end else begin
          w_next = CONVERT;
        end
      end
      READY: begin
        if (w_cs_fall) begin
          w_next        = SHIFT;
          w_enter_shift = 1'b1;
        end else begin
          w_next = READY;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_next        = CONVERT;
          w_leave_shift = 1'b1;
        end else begin
          w_next = SHIFT;
        end
      end
      default: begin
        w_next = CONVERT;
      end
    endcase
  end

  // sck falls only shift while already in SHIFT and cs is not being released.
  assign w_shift_bit = (r_state == SHIFT) && w_sck_fall && !w_cs_rise;

  // Conversion timer, held sample, shift register, bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conv_cnt   <= {CONV_W{1'b0}};
      r_hold_temp  <= {TEMP_W{1'b0}};
      r_hold_open  <= 1'b0;
      r_shreg      <= {FRAME_W{1'b0}};
      r_bit_cnt    <= {BITCNT_W{1'b0}};
      r_so         <= 1'b0;
      r_conv_ready <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if ((r_state == CONVERT) && (w_next == CONVERT)) begin
        r_conv_cnt <= r_conv_cnt + {{(CONV_W-1){1'b0}}, 1'b1};
      end else begin
        r_conv_cnt <= {CONV_W{1'b0}};
      end

      if (w_conv_done) begin
        r_hold_temp <= temp_in;
        r_hold_open <= w_open_eff;
      end

      if (w_enter_shift) begin
        r_shreg   <= build_frame(r_hold_temp, r_hold_open);
        r_so      <= build_frame(r_hold_temp, r_hold_open) >> (FRAME_W - 1) != {FRAME_W{1'b0}};
        r_bit_cnt <= {BITCNT_W{1'b0}};
      end else if (w_leave_shift) begin
        r_so <= 1'b0;
      end else if (w_shift_bit) begin
        r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
        r_so    <= r_shreg[FRAME_W-2];
        if (r_bit_cnt != BITCNT_W'(FRAME_W)) begin
          r_bit_cnt <= r_bit_cnt + {{(BITCNT_W-1){1'b0}}, 1'b1};
        end
      end

      if (w_conv_done) begin
        r_conv_ready <= 1'b1;
      end else if (w_enter_shift) begin
        r_conv_ready <= 1'b0;
      end

      r_frame_done <= w_leave_shift && (r_bit_cnt == BITCNT_W'(FRAME_W));
    end
  end

  assign spi.so     = r_so;
  assign conv_ready = r_conv_ready;
  assign frame_done = r_frame_done;

endmodule
